// File: rtl/bird_column.sv
// rtl/bird_column.sv - one-hot bird position column with gravity, flaps and collision detection
// Optional feature macro: BIRD_CEILING_KILL_EN (ceiling collision also ends the game)
module bird_column #(
  parameter int HEIGHT      = 15,
  parameter int START_ROW   = 7,
  parameter int FALL_PERIOD = 8,
  parameter int FLAP_RISE   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      tick,
  input  logic                      up,
  output logic [HEIGHT-1:0]         leds,
  output logic [$clog2(HEIGHT)-1:0] row,
  output logic                      hit_floor,
  output logic                      hit_ceiling,
  output logic                      dead,
  output logic                      flying
);

  localparam int RW = $clog2(HEIGHT);
  localparam int CW = (FALL_PERIOD > 1) ? $clog2(FALL_PERIOD) : 1;
  // A rise of HEIGHT or more always overshoots, so clamping it keeps the sum inside RW+1 bits.
  localparam int RISE_I = (FLAP_RISE >= HEIGHT) ? HEIGHT : FLAP_RISE;
  localparam logic [RW:0]       RISE_W     = (RW+1)'(RISE_I);
  localparam logic [RW:0]       TOP_W      = (RW+1)'(HEIGHT-1);
  localparam logic [RW-1:0]     TOP_ROW    = RW'(HEIGHT-1);
  localparam logic [RW-1:0]     START_R    = RW'(START_ROW);
  localparam logic [CW-1:0]     LAST_CNT   = CW'(FALL_PERIOD-1);
  localparam logic [HEIGHT-1:0] START_LEDS = HEIGHT'(1) << START_ROW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FLY  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [HEIGHT-1:0] leds_q, leds_d;
  logic [CW-1:0]     fall_cnt_q, fall_cnt_d;
  logic              flap_pending_q, flap_pending_d;
  logic              hit_floor_q, hit_floor_d;
  logic              hit_ceiling_q, hit_ceiling_d;
  logic              dead_q, dead_d;
  logic              flying_q, flying_d;
  logic [RW:0]       target;
  logic              flap_now;

  // Game step: flap latch, flap/gravity position update, collisions and state transitions.
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    fall_cnt_d     = fall_cnt_q;
    flap_pending_d = flap_pending_q;
    hit_floor_d    = 1'b0;
    hit_ceiling_d  = 1'b0;
    target         = {1'b0, row_q} + RISE_W;
    flap_now       = flap_pending_q | up;
    if (state_q != S_DEAD) begin
      if (tick) begin
        flap_pending_d = 1'b0;
        if (flap_now) begin
          state_d    = S_FLY;
          fall_cnt_d = '0;
          if (target > TOP_W) begin
            row_d         = TOP_ROW;
            hit_ceiling_d = 1'b1;
`ifdef BIRD_CEILING_KILL_EN
            state_d       = S_DEAD;
`else
            state_d       = S_FLY;
`endif
          end else begin
            row_d = target[RW-1:0];
          end
        end else if (state_q == S_FLY) begin
          if (fall_cnt_q == LAST_CNT) begin
            fall_cnt_d = '0;
            if (row_q == '0) begin
              hit_floor_d = 1'b1;
              state_d     = S_DEAD;
            end else begin
              row_d = row_q - RW'(1);
            end
          end else begin
            fall_cnt_d = fall_cnt_q + CW'(1);
          end
        end
      end else if (up) begin
        flap_pending_d = 1'b1;
      end
    end
    leds_d   = HEIGHT'(1) << row_d;
    dead_d   = (state_d == S_DEAD);
    flying_d = (state_d == S_FLY);
  end

  // State and registered outputs; reset overrides any coincident tick/up.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      row_q          <= START_R;
      leds_q         <= START_LEDS;
      fall_cnt_q     <= '0;
      flap_pending_q <= 1'b0;
      hit_floor_q    <= 1'b0;
      hit_ceiling_q  <= 1'b0;
      dead_q         <= 1'b0;
      flying_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      leds_q         <= leds_d;
      fall_cnt_q     <= fall_cnt_d;
      flap_pending_q <= flap_pending_d;
      hit_floor_q    <= hit_floor_d;
      hit_ceiling_q  <= hit_ceiling_d;
      dead_q         <= dead_d;
      flying_q       <= flying_d;
    end
  end

  assign leds        = leds_q;
  assign row         = row_q;
  assign hit_floor   = hit_floor_q;
  assign hit_ceiling = hit_ceiling_q;
  assign dead        = dead_q;
  assign flying      = flying_q;

endmodule
